// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundles the requester handshake and the uart_tx
// control/status wires seen by the arbiter. The slave modport is the arbiter
// side; the master modport is the requesters plus the transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_Req;
  logic [8*NUM_REQ-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   o_Grant;
  logic [NUM_REQ-1:0]   o_Req_Done;
  logic                 o_Busy;
  logic                 o_Tx_DV;
  logic [7:0]           o_Tx_Byte;
  logic                 i_Tx_Active;
  logic                 i_Tx_Done;

  modport slave (
    input  i_Req, i_Req_Byte, i_Tx_Active, i_Tx_Done,
    output o_Grant, o_Req_Done, o_Busy, o_Tx_DV, o_Tx_Byte
  );

  modport master (
    output i_Req, i_Req_Byte, i_Tx_Active, i_Tx_Done,
    input  o_Grant, o_Req_Done, o_Busy, o_Tx_DV, o_Tx_Byte
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte producers.
// Pending requests are served round-robin starting after the last grant; the
// transmitter's Active/Done outputs gate every new byte so nothing is dropped,
// even when the arbiter is reset while uart_tx (which has no reset) is mid-frame.
// Build option: define UART_TX_ARB_FIXED_PRIO_EN for strict priority (lowest
// index wins); the pointer then only steers the o_Req_Done pulse.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  uart_tx_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RESYNC    = 2'd0,
    ST_ARB       = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ-1);

  state_t           state_r;
  logic [IDX_W-1:0] ptr_r;

  logic [IDX_W-1:0] start_s;
  logic [IDX_W:0]   scan_s;
  logic             hit_s;
  logic             win_found_s;
  logic [IDX_W-1:0] win_idx_s;

  // First index examined by the scan: one past the last grant, or 0 for strict priority.
  always_comb begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    start_s = '0;
`else
    if (ptr_r == LAST_IDX) begin
      start_s = '0;
    end else begin
      start_s = ptr_r + IDX_W'(1);
    end
`endif
  end

  // Circular scan from start_s; the first pending request found is the winner.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    scan_s      = '0;
    hit_s       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_s      = {1'b0, start_s} + (IDX_W+1)'(i);
      scan_s      = (scan_s >= (IDX_W+1)'(NUM_REQ)) ? (scan_s - (IDX_W+1)'(NUM_REQ)) : scan_s;
      hit_s       = ~win_found_s & bus.i_Req[scan_s[IDX_W-1:0]];
      win_idx_s   = hit_s ? scan_s[IDX_W-1:0] : win_idx_s;
      win_found_s = win_found_s | hit_s;
    end
  end

  // Arbitration FSM; every output is a register and pulses default low each cycle.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_r        <= ST_RESYNC;
      ptr_r          <= LAST_IDX;
      bus.o_Grant    <= '0;
      bus.o_Req_Done <= '0;
      bus.o_Busy     <= 1'b0;
      bus.o_Tx_DV    <= 1'b0;
      bus.o_Tx_Byte  <= 8'h00;
    end else begin
      bus.o_Grant    <= '0;
      bus.o_Req_Done <= '0;
      bus.o_Tx_DV    <= 1'b0;
      case (state_r)
        ST_RESYNC: begin
          // Transmitter must be fully idle (past CLEANUP and its trailing Done) before the next byte.
          if (!bus.i_Tx_Active && !bus.i_Tx_Done) begin
            state_r    <= ST_ARB;
            bus.o_Busy <= 1'b0;
          end
        end
        ST_ARB: begin
          if (win_found_s) begin
            bus.o_Tx_Byte <= bus.i_Req_Byte[{win_idx_s, 3'b000} +: 8];
            bus.o_Tx_DV   <= 1'b1;
            bus.o_Grant   <= ONE_HOT0 << win_idx_s;
            bus.o_Busy    <= 1'b1;
            ptr_r         <= win_idx_s;
            state_r       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (bus.i_Tx_Done) begin
            bus.o_Req_Done <= ONE_HOT0 << ptr_r;
            state_r        <= ST_RESYNC;
          end
        end
        default: begin
          state_r <= ST_RESYNC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench pairing the arbiter with a behavioural
// uart_tx (4 clocks per bit, no reset) and a serial-line receiver. Expected
// grant orders and wire bytes are hand-computed constants; define
// UART_TX_ARB_FIXED_PRIO_EN to switch expectations to strict priority.
module tb_uart_tx_arbiter;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [31:0] req_byte = 32'h0;
  logic        tx_active = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_serial = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  assign bus.i_Req       = req;
  assign bus.i_Req_Byte  = req_byte;
  assign bus.i_Tx_Active = tx_active;
  assign bus.i_Tx_Done   = tx_done;

  uart_tx_arbiter #(.NUM_REQ(4), .IDX_W(2)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  // ---------------- behavioural uart_tx (no reset) ----------------
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_STOP, T_CLEAN} tx_st_t;
  tx_st_t     tx_st = T_IDLE;
  logic [7:0] tx_data = 8'h00;
  int         tx_cnt = 0;
  int         tx_bit = 0;

  always @(posedge clk) begin
    case (tx_st)
      T_IDLE: begin
        tx_serial <= 1'b1;
        tx_done   <= 1'b0;
        tx_cnt    <= 0;
        tx_bit    <= 0;
        if (bus.o_Tx_DV) begin
          tx_active <= 1'b1;
          tx_data   <= bus.o_Tx_Byte;
          tx_st     <= T_START;
        end
      end
      T_START: begin
        tx_serial <= 1'b0;
        if (tx_cnt < CPB-1) tx_cnt <= tx_cnt + 1;
        else begin tx_cnt <= 0; tx_st <= T_DATA; end
      end
      T_DATA: begin
        tx_serial <= tx_data[tx_bit];
        if (tx_cnt < CPB-1) tx_cnt <= tx_cnt + 1;
        else begin
          tx_cnt <= 0;
          if (tx_bit < 7) tx_bit <= tx_bit + 1;
          else begin tx_bit <= 0; tx_st <= T_STOP; end
        end
      end
      T_STOP: begin
        tx_serial <= 1'b1;
        if (tx_cnt < CPB-1) tx_cnt <= tx_cnt + 1;
        else begin
          tx_cnt    <= 0;
          tx_done   <= 1'b1;
          tx_active <= 1'b0;
          tx_st     <= T_CLEAN;
        end
      end
      T_CLEAN: begin
        tx_done <= 1'b1;
        tx_st   <= T_IDLE;
      end
      default: tx_st <= T_IDLE;
    endcase
  end

  // ---------------- serial-line receiver ----------------
  logic       rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  int         frame_bad = 0;
  int         wire_q[$];

  always @(posedge clk) begin
    if (!rx_busy) begin
      if (!tx_serial) begin rx_busy <= 1'b1; rx_cnt <= 1; end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 6) % 4) == 0)
        rx_sh <= {tx_serial, rx_sh[7:1]};
      if (rx_cnt == 38) begin
        rx_busy <= 1'b0;
        if (!tx_serial) frame_bad <= frame_bad + 1;
        wire_q.push_back(int'(rx_sh));
      end
    end
  end

  // ---------------- output monitors ----------------
  int   cyc = 0;
  int   dv_cnt = 0, dv_bad = 0, gap_bad = 0, grant_bad = 0, rdone_bad = 0;
  int   last_done_cyc = -100;
  logic dv_q = 1'b0, done_q = 1'b0, rd_q = 1'b0;
  int   grant_q[$];
  int   rdone_q[$];

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    dv_q   <= bus.o_Tx_DV;
    done_q <= tx_done;
    rd_q   <= (bus.o_Req_Done != 4'b0000);
    if (tx_done && !done_q) last_done_cyc <= cyc;
    if (bus.o_Tx_DV) begin
      dv_cnt <= dv_cnt + 1;
      if (dv_q || tx_active || tx_done) dv_bad <= dv_bad + 1;
      if (!dv_q && (cyc - last_done_cyc) < 3) gap_bad <= gap_bad + 1;
    end
    if (bus.o_Grant != 4'b0000) begin
      if (!$onehot(bus.o_Grant) || !bus.o_Tx_DV) grant_bad <= grant_bad + 1;
      for (int k = 0; k < 4; k++) if (bus.o_Grant[k]) grant_q.push_back(k);
    end else if (bus.o_Tx_DV) grant_bad <= grant_bad + 1;
    if (bus.o_Req_Done != 4'b0000) begin
      if (!$onehot(bus.o_Req_Done) || rd_q) rdone_bad <= rdone_bad + 1;
      for (int k = 0; k < 4; k++) if (bus.o_Req_Done[k]) rdone_q.push_back(k);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_rdone(input string tag, input int n, input int budget);
    int k = 0;
    while (rdone_q.size() < n && k < budget) begin tick(1); k++; end
    check(tag, 32'(rdone_q.size() >= n), 32'd1);
  endtask

  task automatic wait_grant(input string tag, input int budget);
    int k = 0;
    while (bus.o_Grant == 4'b0000 && k < budget) begin tick(1); k++; end
    check(tag, 32'(bus.o_Grant != 4'b0000), 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int gb, rb, wb, db, exp_idx;

    // Reset state
    tick(3);
    check("rst_grant", 32'(bus.o_Grant), 32'h0);
    check("rst_done",  32'(bus.o_Req_Done), 32'h0);
    check("rst_busy",  32'(bus.o_Busy), 32'h0);
    check("rst_dv",    32'(bus.o_Tx_DV), 32'h0);
    check("rst_byte",  32'(bus.o_Tx_Byte), 32'h0);
    rst = 1'b0;
    tick(3);

    // 1: single request, one-cycle grant latency, 0x55 on the wire
    wb = wire_q.size(); rb = rdone_q.size(); db = dv_cnt;
    req_byte = 32'hA3A2_A155; req = 4'b0001;
    tick(1);
    check("t1_grant", 32'(bus.o_Grant), 32'h1);
    check("t1_dv",    32'(bus.o_Tx_DV), 32'h1);
    check("t1_byte",  32'(bus.o_Tx_Byte), 32'h55);
    check("t1_busy",  32'(bus.o_Busy), 32'h1);
    req = 4'b0000;
    tick(1);
    check("t1_dv_low", 32'(bus.o_Tx_DV), 32'h0);
    wait_rdone("t1_wait", rb + 1, 200);
    check("t1_rdone_idx", 32'(rdone_q[rb]), 32'd0);
    tick(8);
    check("t1_busy_clr", 32'(bus.o_Busy), 32'h0);
    check("t1_dv_cnt",   32'(dv_cnt - db), 32'd1);
    check("t1_rdone_n",  32'(rdone_q.size() - rb), 32'd1);
    check("t1_wire_n",   32'(wire_q.size() - wb), 32'd1);
    check("t1_wire",     32'(wire_q[wb]), 32'h55);

    // 2: all four request; round-robin from index 0 after reset
    pulse_reset();
    gb = grant_q.size(); wb = wire_q.size(); rb = rdone_q.size(); db = dv_cnt;
    req_byte = 32'hA3A2_A1A0; req = 4'b1111;
    wait_rdone("t2_wait", rb + 5, 400);
    req = 4'b0000;
    tick(10);
    check("t2_grant_n", 32'(grant_q.size() - gb), 32'd5);
    check("t2_dv_n",    32'(dv_cnt - db), 32'd5);
    check("t2_wire_n",  32'(wire_q.size() - wb), 32'd5);
    for (int i = 0; i < 5; i++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      exp_idx = 0;
`else
      exp_idx = i % 4;
`endif
      check($sformatf("t2_grant%0d", i), 32'(grant_q[gb+i]), 32'(exp_idx));
      check($sformatf("t2_rdone%0d", i), 32'(rdone_q[rb+i]), 32'(exp_idx));
      check($sformatf("t2_wire%0d", i),  32'(wire_q[wb+i]), 32'hA0 + 32'(exp_idx));
    end

    // 3: sole requester held, back-to-back frames
    gb = grant_q.size(); wb = wire_q.size(); rb = rdone_q.size(); db = dv_cnt;
    req = 4'b0100;
    wait_rdone("t3_wait", rb + 5, 400);
    req = 4'b0000;
    tick(10);
    check("t3_grant_n", 32'(grant_q.size() - gb), 32'd5);
    check("t3_rdone_n", 32'(rdone_q.size() - rb), 32'd5);
    check("t3_dv_n",    32'(dv_cnt - db), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_grant%0d", i), 32'(grant_q[gb+i]), 32'd2);
      check($sformatf("t3_wire%0d", i),  32'(wire_q[wb+i]), 32'hA2);
    end

    // 4: reset during the third data bit of index 1's frame
    wb = wire_q.size();
    req_byte = 32'hA3A2_B1A0; req = 4'b0010;
    wait_grant("t4_grant_wait", 50);
    check("t4_first_grant", 32'(bus.o_Grant), 32'h2);
    begin
      int k = 0;
      while (!(tx_st == T_DATA && tx_bit == 2) && k < 60) begin tick(1); k++; end
      check("t4_bit2_wait", 32'(tx_st == T_DATA && tx_bit == 2), 32'd1);
    end
    gb = grant_q.size(); rb = rdone_q.size();
    rst = 1'b1;
    req_byte = 32'hA3A2_B13C; req = 4'b0011;
    tick(1);
    rst = 1'b0;
    check("t4_rst_busy",  32'(bus.o_Busy), 32'h0);
    check("t4_rst_grant", 32'(bus.o_Grant), 32'h0);
    check("t4_rst_dv",    32'(bus.o_Tx_DV), 32'h0);
    wait_rdone("t4_wait", rb + 1, 200);
    req = 4'b0000;
    tick(10);
    check("t4_grant_idx", 32'(grant_q[gb]), 32'd0);
    check("t4_rdone_idx", 32'(rdone_q[rb]), 32'd0);
    check("t4_rdone_n",   32'(rdone_q.size() - rb), 32'd1);
    check("t4_wire_n",    32'(wire_q.size() - wb), 32'd2);
    check("t4_wire0",     32'(wire_q[wb]), 32'hB1);
    check("t4_wire1",     32'(wire_q[wb+1]), 32'h3C);

    // 5: index 1 pulses a request while busy and withdraws it before ARB
    gb = grant_q.size(); rb = rdone_q.size(); db = dv_cnt;
    req = 4'b1000;
    wait_grant("t5_grant_wait", 50);
    check("t5_grant", 32'(bus.o_Grant), 32'h8);
    req = 4'b0000;
    tick(10);
    req = 4'b0010;
    tick(1);
    req = 4'b0000;
    wait_rdone("t5_wait", rb + 1, 200);
    tick(20);
    check("t5_grant_n", 32'(grant_q.size() - gb), 32'd1);
    check("t5_dv_n",    32'(dv_cnt - db), 32'd1);
    check("t5_rdone",   32'(rdone_q[rb]), 32'd3);

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    // 6: strict priority, lowest pending index always wins
    gb = grant_q.size(); rb = rdone_q.size();
    req = 4'b1110;
    wait_rdone("t6_wait", rb + 3, 300);
    req = 4'b0000;
    tick(10);
    for (int i = 0; i < 3; i++)
      check($sformatf("t6_grant%0d", i), 32'(grant_q[gb+i]), 32'd1);
`endif

    // Protocol invariants gathered over the whole run
    check("dv_single_idle", 32'(dv_bad), 32'd0);
    check("dv_gap",         32'(gap_bad), 32'd0);
    check("grant_shape",    32'(grant_bad), 32'd0);
    check("rdone_shape",    32'(rdone_bad), 32'd0);
    check("frame_stop",     32'(frame_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
